// File: rtl/mips_mem_responder.sv
// Unified instruction/data word memory answering the MIPS core's req/ack requests.
// Fixed programmable wait states, registered ack/rdata/err, fault flag for misaligned or
// out-of-range accesses. Optional per-byte write enables when MIPS_MEM_BYTE_EN is defined.
// Assumes ADDR_WIDTH > log2(DEPTH_WORDS) + 2.
module mips_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
`ifdef MIPS_MEM_BYTE_EN
  input  logic [DATA_WIDTH/8-1:0] be,
`endif
  output logic                    ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic                    busy
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned BeW  = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BeW-1:0]        be_q, be_in;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic                  capture, enter_resp, fault, mem_we;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [BeW-1:0]        acc_be;
  logic [IdxW-1:0]       idx;

`ifdef MIPS_MEM_BYTE_EN
  assign be_in = be;
`else
  assign be_in = '1;
`endif

  // With zero wait states the access completes on the capture edge, so use the live
  // inputs in IDLE and the held copies otherwise.
  always_comb begin
    capture    = (state_q == StIdle) && req;
    acc_we     = (state_q == StIdle) ? we    : we_q;
    acc_addr   = (state_q == StIdle) ? addr  : addr_q;
    acc_wdata  = (state_q == StIdle) ? wdata : wdata_q;
    acc_be     = (state_q == StIdle) ? be_in : be_q;
    idx        = acc_addr[IdxW+1:2];
    fault      = (acc_addr[1:0] != 2'b00) || (acc_addr[ADDR_WIDTH-1:IdxW+2] != '0);
    enter_resp = (capture && (WAIT_STATES == 0)) || ((state_q == StWait) && (cnt_q == 4'd1));
    mem_we     = enter_resp && acc_we && !fault;
  end

  // Next-state, counter and registered response values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (enter_resp) begin
      ack_d = 1'b1;
      err_d = fault;
      if (!acc_we && !fault) rdata_d = mem_q[idx];
    end
  end

  // State, holding registers and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (capture) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= be_in;
      end
    end
  end

  // Storage write on the edge entering RESP; array is not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BeW; i++) begin
        if (acc_be[i]) mem_q[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Unified instruction/data word memory that answers the multi-cycle MIPS core's memory requests: instruction fetch at the PC, and lw/sw data access.
- The core is the initiator. This block is the responder end of the req/ack interface.
- It has a programmable fixed number of wait states, so the core's control FSM can be exercised against slow memory.
- It reports misaligned or out-of-range accesses on an error flag returned with ack.

Parameters:
- ADDR_WIDTH, 32, byte-address width; matches MIPS_PC_WIDTH.
- DATA_WIDTH, 32, word width; matches MIPS_DATA_WIDTH.
- DEPTH_WORDS, 256, number of words in storage; power of two, at least 4.
- WAIT_STATES, 2, cycles spent in WAIT before ack; range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  request from core; sampled only in IDLE.
- we  in  1  1 = write (sw), 0 = read (fetch or lw); captured with req.
- addr  in  ADDR_WIDTH  byte address; captured with req.
- wdata  in  DATA_WIDTH  write data; captured with req.
- be  in  DATA_WIDTH/8  byte enables; present only with MIPS_MEM_BYTE_EN.
- ack  out  1  one-cycle completion pulse.
- rdata  out  DATA_WIDTH  read data; valid only while ack=1 and we=0.
- err  out  1  access fault; valid only while ack=1.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, ack=0, rdata=0, err=0, busy=0, wait counter=0. Memory array is not reset.
- Reset asserted mid-transaction aborts it: no write occurs and no ack is issued.
- FSM states IDLE, WAIT, RESP:
  - IDLE: when req=1, capture we/addr/wdata(/be) into holding registers and load counter=WAIT_STATES. Next state is WAIT if WAIT_STATES>0, else RESP.
  - WAIT: counter decrements each cycle. Move to RESP in the cycle after counter reaches 1.
  - RESP: ack=1 for exactly this cycle, then return to IDLE.
- Latency: ack is asserted WAIT_STATES+1 cycles after the cycle in which req is sampled.
  - WAIT_STATES=0: ack in the cycle after req.
- Outputs ack, rdata and err are registered; there is no combinational path from req/addr to them.
- Word index is the captured addr[ADDR_WIDTH-1:2], truncated to log2(DEPTH_WORDS) bits after the range check.
- Fault detection, on captured values:
  - misaligned: addr[1:0] != 0.
  - out of range: word index >= DEPTH_WORDS.
  - On fault: err=1 with ack, rdata=0, no write performed.
- Write: memory updated at the clock edge that enters RESP, so a read issued immediately afterwards returns the new data.
- Read: rdata is the word at the captured address; it is held at 0 whenever ack=0.
- Handshake rules:
  - The core holds req until ack.
  - req is ignored in WAIT and RESP; dropping it mid-transaction does not cancel the access.
  - If req is still high in the cycle after ack (state back in IDLE), a new transaction starts. Back-to-back throughput is one access per WAIT_STATES+2 cycles.
- Inputs that change after capture have no effect on the in-flight access.

Optional Feature:
- Macro: MIPS_MEM_BYTE_EN.
- Defined:
  - be port exists.
  - On a write, only the byte lanes with be[i]=1 are updated.
  - be is ignored on reads.
  - be=0000 on a write is a legal no-op that still acks with err=0.
- Undefined:
  - No be port.
  - Every write updates the full word.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, then 1 with req=0 for 10 cycles -> ack, err, busy and rdata stay 0.
- Write then read, WAIT_STATES=2: write 0xDEADBEEF to addr 0x10, then read addr 0x10 -> each ack arrives exactly 3 cycles after req is sampled; read returns rdata=0xDEADBEEF, err=0.
- WAIT_STATES=0, back-to-back reads at 0x0, 0x4, 0x8 with req held high -> ack every 2nd cycle, and each word matches what was preloaded.
- Faults: read addr 0x6 -> ack with err=1, rdata=0. Write 0x55 to addr 0x400 (DEPTH_WORDS=256) -> err=1, and a later read of addr 0x0 is unchanged.
- Abort and cancel:
  - Assert rst_n=0 in WAIT of a write to 0x20 -> no ack; memory word at 0x20 unchanged.
  - Separately, drop req in WAIT -> ack still occurs on schedule.
- MIPS_MEM_BYTE_EN: word at 0x20 = 0x11223344; write 0xAABBCCDD with be=0101 -> reading 0x20 returns 0x11BB33DD.
